// File: rtl/mulu_seq_ctrl.sv
// Sequential unsigned shift-add multiplier, one add/shift step per clock; done pulses WIDTH edges after start.
// No backpressure: start is taken only in IDLE and ignored (not queued) while busy; c holds until the next done.
module mulu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic               c_r;
    logic [WIDTH-1:0]   p_r;
    logic [WIDTH-1:0]   y_r;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    // One partial-product step: conditional add into the high half, then shift {C,P,Y} right.
    always_comb begin
        sum     = {c_r, p_r} + (y_r[0] ? {1'b0, a_r} : '0);
        shifted = {sum, y_r} >> 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            c_r   <= 1'b0;
            p_r   <= '0;
            y_r   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            c     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        y_r   <= b;
                        p_r   <= '0;
                        c_r   <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    {c_r, p_r, y_r} <= shifted;
                    cnt             <= cnt + CW'(1);
                    // The last step publishes the post-shift product directly.
                    if (cnt == CW'(WIDTH - 1)) begin
                        c     <= shifted[2*WIDTH-1:0];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mulu_seq_ctrl.sv
// Bench for mulu_seq_ctrl: WIDTH=8 directed cases plus WIDTH=4 exhaustive, against a cycle-count/product model.
module tb_mulu_seq_ctrl;
    localparam int W8 = 8;
    localparam int W4 = 4;

    logic        clk;
    logic        rst;

    logic        start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    logic        start4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  c4;

    int compared = 0;
    int mismatched = 0;
    bit en = 1'b0;

    mulu_seq_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .c(c8)
    );

    mulu_seq_ctrl #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .c(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph = edges elapsed since the accepted start edge (0 = idle).
    // Busy spans ph 1..W+1, done is high only at ph W+1, product lands at ph W+1.
    int          ph8 = 0;
    logic [15:0] pend8 = '0;
    logic [15:0] cexp8 = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph8 = 0;
            cexp8 = '0;
        end else if (ph8 == 0) begin
            if (start8) begin
                ph8 = 1;
                pend8 = 16'(a8) * 16'(b8);
            end
        end else if (ph8 == W8 + 1) begin
            ph8 = 0;
        end else begin
            ph8++;
            if (ph8 == W8 + 1) cexp8 = pend8;
        end
    end

    int         ph4 = 0;
    logic [7:0] pend4 = '0;
    logic [7:0] cexp4 = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph4 = 0;
            cexp4 = '0;
        end else if (ph4 == 0) begin
            if (start4) begin
                ph4 = 1;
                pend4 = 8'(a4) * 8'(b4);
            end
        end else if (ph4 == W4 + 1) begin
            ph4 = 0;
        end else begin
            ph4++;
            if (ph4 == W4 + 1) cexp4 = pend4;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("busy8", 32'(busy8), 32'(ph8 != 0));
            chk("done8", 32'(done8), 32'(ph8 == W8 + 1));
            chk("c8",    32'(c8),    32'(cexp8));
            chk("busy4", 32'(busy4), 32'(ph4 != 0));
            chk("done4", 32'(done4), 32'(ph4 == W4 + 1));
            chk("c4",    32'(c4),    32'(cexp4));
        end
    end

    task automatic start_op8(input logic [7:0] x, input logic [7:0] y);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string name);
        int n;
        start_op8(x, y);
        wait_done8(n);
        chk({name, "_lat"}, 32'(n), 32'(W8));
        chk({name, "_c"}, 32'(c8), 32'(exp));
        @(negedge clk);
        chk({name, "_donelow"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int n;
        int cnt_done;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_c8",    32'(c8),    32'd0);
        chk("rst_c4",    32'(c4),    32'd0);
        rst = 1'b0;
        en = 1'b1;
        @(negedge clk);

        run8(8'd255, 8'd255, 16'hFE01, "max");
        run8(8'd0,   8'd200, 16'd0,    "zero_a");
        run8(8'd200, 8'd0,   16'd0,    "zero_b");
        run8(8'd1,   8'd173, 16'd173,  "one");

        // Operand change and a second start during RUN must not disturb the op.
        start_op8(8'd12, 8'd13);
        a8 = 8'd99;
        b8 = 8'd99;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        chk("ign_lat", 32'(n), 32'd5);
        chk("ign_c", 32'(c8), 32'd156);
        cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) cnt_done++;
        end
        chk("ign_extra_done", 32'(cnt_done), 32'd0);

        // start held high: the next op is sampled on the first IDLE edge after DONE.
        a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
        @(negedge clk);
        wait_done8(n);
        chk("b2b1_lat", 32'(n), 32'd8);
        chk("b2b1_c", 32'(c8), 32'd15);
        a8 = 8'd7; b8 = 8'd9;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 40);
        chk("b2b2_lat", 32'(n), 32'd10);
        chk("b2b2_c", 32'(c8), 32'd63);
        start8 = 1'b0;
        @(negedge clk);

        // Asynchronous abort after four steps.
        start_op8(8'd100, 8'd100);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_c",    32'(c8),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) cnt_done++;
        end
        chk("abort_no_done", 32'(cnt_done), 32'd0);
        run8(8'd2, 8'd3, 16'd6, "after_abort");

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x);
                b4 = 4'(y);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                n = 0;
                while (!done4 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("w4_lat", 32'(n), 32'(W4));
                chk("w4_c", 32'(c4), 32'(x * y));
                @(negedge clk);
            end
        end

        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
